// File: rtl/bus_pkg.sv
// Shared bus definitions: request mode encoding, slave FSM states, wait counter width.
package bus_pkg;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_MEM,
    ST_RD2,
    ST_RESP
  } slv_state_t;

endpackage

// File: rtl/bram_sp.sv
// Single-port synchronous block RAM, one-cycle read latency, contents not reset.
module bram_sp #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4096
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/bram_slave_port.sv
// Bus slave responder in front of a local block RAM: one request at a time, range-checked.
// Optional RAM output register stage is enabled by defining BRAM_SLAVE_OUTREG_EN.
//
// state   | meaning
// IDLE    | s_ready high, waiting for a request
// WAIT    | inserted busy cycles before the memory access
// MEM     | RAM access issued on the exiting edge
// RD2     | RAM output register stage (BRAM_SLAVE_OUTREG_EN only)
// RESP    | s_rvalid strobe with read data
module bram_slave_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_DEPTH   = 4096,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_valid,
  input  logic                  s_mode,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  output logic                  s_ready,
  output logic                  s_rvalid,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic                  s_err
);

  localparam int RAM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    WAIT_CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

`ifdef BRAM_SLAVE_OUTREG_EN
  localparam slv_state_t RD_NEXT = ST_RD2;
`else
  localparam slv_state_t RD_NEXT = ST_RESP;
`endif

  slv_state_t state, state_nxt;
  logic [WAIT_CNT_W-1:0] cnt, cnt_nxt;
  logic                  mode_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_hold, ram_rdata, rd_data;
  logic                  accept, oor, ram_en, wr_err_q;

  assign accept = s_valid && s_ready;
  assign oor    = {1'b0, addr_q} >= DEPTH_LIM;
  // Out-of-range accesses never touch the RAM, so discarded writes need no extra gating.
  assign ram_en = (state == ST_MEM) && !oor;

  bram_sp #(
    .ADDR_WIDTH(RAM_AW),
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (MEM_DEPTH)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (mode_q == MODE_WRITE),
    .addr (addr_q[RAM_AW-1:0]),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

`ifdef BRAM_SLAVE_OUTREG_EN
  logic [DATA_WIDTH-1:0] rd_pipe;
  always_ff @(posedge clk) begin
    if (state == ST_RD2) rd_pipe <= ram_rdata;
  end
  assign rd_data = rd_pipe;
`else
  assign rd_data = ram_rdata;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = WAIT_LOAD;
          end else begin
            state_nxt = ST_MEM;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == '0) state_nxt = ST_MEM;
        else           cnt_nxt   = cnt - WAIT_CNT_W'(1);
      end
      ST_MEM:  state_nxt = (mode_q == MODE_WRITE) ? ST_IDLE : RD_NEXT;
      ST_RD2:  state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q     <= MODE_READ;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_hold <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        mode_q  <= s_mode;
        addr_q  <= s_addr;
        wdata_q <= s_wdata;
      end
      if (s_rvalid) rdata_hold <= s_rdata;
      wr_err_q <= (state == ST_MEM) && (mode_q == MODE_WRITE) && oor;
    end
  end

  assign s_ready  = (state == ST_IDLE);
  assign s_rvalid = (state == ST_RESP);
  // Read data is live during the strobe and held afterwards until the next read response.
  assign s_rdata  = s_rvalid ? (oor ? '0 : rd_data) : rdata_hold;
  assign s_err    = (s_rvalid && oor) || wr_err_q;

endmodule

// File: tb/tb_bram_slave_port.sv
// Randomized scoreboard bench for bram_slave_port: two lanes (default config, and
// WAIT_CYCLES=3 / MEM_DEPTH=2048), each with its own driver, reference model and monitor.
module tb_bram_slave_port;

`ifdef BRAM_SLAVE_OUTREG_EN
  localparam int RDX = 1;
`else
  localparam int RDX = 0;
`endif

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       err;
    logic       is_read;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int lane, input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL lane%0d %s at cycle %0d: got %0h expected %0h", lane, nm, cyc, act, expv);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int W = (g == 0) ? 0 : 3;
    localparam int D = (g == 0) ? 4096 : 2048;

    logic        rstn = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_mode = 1'b0;
    logic [11:0] s_addr = '0;
    logic [7:0]  s_wdata = '0;
    logic        s_ready, s_rvalid, s_err;
    logic [7:0]  s_rdata;

    exp_t        q[$];
    logic [7:0]  model [4096];
    logic [11:0] pool [8];
    int          busy_until = 0;
    logic [7:0]  hold = '0;
    bit          done = 1'b0;

    bram_slave_port #(
      .ADDR_WIDTH (12),
      .DATA_WIDTH (8),
      .MEM_DEPTH  (D),
      .WAIT_CYCLES(W)
    ) dut (
      .clk     (clk),
      .rstn    (rstn),
      .s_valid (s_valid),
      .s_mode  (s_mode),
      .s_addr  (s_addr),
      .s_wdata (s_wdata),
      .s_ready (s_ready),
      .s_rvalid(s_rvalid),
      .s_rdata (s_rdata),
      .s_err   (s_err)
    );

    // Presents a request (after an optional idle gap) and records the expected outcome
    // at the negedge before the accepting edge n.
    task automatic issue(input logic m, input logic [11:0] a, input logic [7:0] d,
                         input int gap);
      exp_t e;
      int   n;
      bit   ok;
      if (gap > 0) begin
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      s_valid = 1'b1;
      s_mode  = m;
      s_addr  = a;
      s_wdata = d;
      ok = 1'b0;
      for (int t = 0; t < 40 && !ok; t++) begin
        if (s_ready) begin
          ok = 1'b1;
          n  = cyc + 1;
          e.cyc     = n + 1 + W;
          e.data    = '0;
          e.err     = (int'(a) >= D);
          e.is_read = !m;
          if (m) begin
            if (int'(a) < D) model[a] = d;
            busy_until = n + 1 + W;
            if (e.err) q.push_back(e);
          end else begin
            e.cyc += RDX;
            if (int'(a) < D) e.data = model[a];
            busy_until = n + 2 + W + RDX;
            q.push_back(e);
          end
        end
        @(negedge clk);
      end
      if (!ok) chk(g, "accept_timeout", 32'(0), 32'(1));
    endtask

    initial begin
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      issue(1'b1, 12'h123, 8'hA5, 0);
      issue(1'b0, 12'h123, 8'h00, 0);
      issue(1'b1, 12'h100, 8'h77, 1);
      issue(1'b1, 12'h900, 8'h3C, 0);
      issue(1'b0, 12'h100, 8'h00, 0);
      issue(1'b0, 12'h900, 8'h00, 0);
      issue(1'b1, 12'h020, 8'h42, 1);
      issue(1'b0, 12'h123, 8'h00, 1);
      // A write presented while busy must be ignored entirely.
      s_valid = 1'b1; s_mode = 1'b1; s_addr = 12'h020; s_wdata = 8'hFF;
      @(negedge clk);
      s_valid = 1'b0;
      issue(1'b0, 12'h020, 8'h00, 2);
      issue(1'b1, 12'h030, 8'h11, 1);
      issue(1'b1, 12'h030, 8'h99, 0);
      // Reset before the MEM edge of the 0x99 write: it must never land.
      s_valid = 1'b0;
      rstn = 1'b0;
      busy_until = 0;
      q.delete();
      hold = '0;
      model[12'h030] = 8'h11;
      @(negedge clk);
      rstn = 1'b1;
      issue(1'b0, 12'h030, 8'h00, 1);

      pool = '{12'h000, 12'h001, 12'h7FF, 12'h800, 12'h555, 12'hFFF, 12'h0AA, 12'h123};
      for (int i = 0; i < 8; i++) issue(1'b1, pool[i], 8'($urandom), 0);
      for (int i = 0; i < 60; i++)
        issue(1'($urandom), pool[$urandom_range(0, 7)], 8'($urandom), int'($urandom_range(0, 2)));
      s_valid = 1'b0;
      repeat (30) @(negedge clk);
      chk(g, "drain", 32'(q.size()), 32'(0));
      done = 1'b1;
    end

    initial forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (!rstn) begin
        chk(g, "rst_ready", 32'(s_ready), 32'(1));
        chk(g, "rst_rvalid", 32'(s_rvalid), 32'(0));
        chk(g, "rst_rdata", 32'(s_rdata), 32'(0));
        chk(g, "rst_err", 32'(s_err), 32'(0));
      end else begin
        if (s_rvalid || s_err) begin
          if (q.size() == 0) begin
            chk(g, "unexpected_resp", 32'({s_rvalid, s_err}), 32'(0));
          end else begin
            e = q.pop_front();
            chk(g, "resp_cycle", 32'(cyc), 32'(e.cyc));
            chk(g, "rvalid", 32'(s_rvalid), 32'(e.is_read));
            chk(g, "err", 32'(s_err), 32'(e.err));
            if (e.is_read) begin
              chk(g, "rdata", 32'(s_rdata), 32'(e.data));
              hold = e.data;
            end
          end
        end else begin
          chk(g, "rdata_hold", 32'(s_rdata), 32'(hold));
          if (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            chk(g, "resp_missing", 32'(cyc), 32'(e.cyc));
          end
        end
        chk(g, "ready", 32'(s_ready), 32'(cyc >= busy_until));
      end
    end
  end

  initial begin
    bit fin;
    fin = 1'b0;
    for (int t = 0; t < 20000 && !fin; t++) begin
      @(posedge clk);
      fin = lane[0].done && lane[1].done;
    end
    if (!fin) chk(0, "global_timeout", 32'(0), 32'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
